// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one 1-bit ALU slice LSB-first for WIDTH cycles.
// Optional abort input enabled by defining ALU_SERIAL_ABORT_EN.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef ALU_SERIAL_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             sl_src1_o,
    output logic             sl_src2_o,
    output logic             sl_cin_o,
    output logic             sl_ainv_o,
    output logic             sl_binv_o,
    output logic [1:0]       sl_op_o,
    output logic             sl_less_o,
    input  logic             sl_result_i,
    input  logic             sl_cout_i
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IdxLast = IW'(WIDTH - 1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpNand = 4'b1101;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             run;
    logic             last;
    logic             ovf_c;
    logic [WIDTH-1:0] full_c;
    logic             ainv, binv;
    logic [1:0]       op;

    function automatic logic op_valid(input logic [3:0] c);
        return c inside {OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpNor, OpNand};
    endfunction

    assign run    = (state_q == StRun);
    assign last   = (idx_q == IdxLast);
    // carry_q holds the MSB carry-in on the final bit
    assign ovf_c  = carry_q ^ sl_cout_i;
    assign full_c = {sl_result_i, work_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        work_d   = work_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    ctrl_d  = ctrl_i;
                    idx_d   = '0;
                    work_d  = '0;
                    carry_d = (ctrl_i == OpSub) || (ctrl_i == OpSlt);
                    if (op_valid(ctrl_i)) begin
                        state_d = StRun;
                    end else begin
                        state_d  = StDone;
                        result_d = '0;
                        zero_d   = 1'b1;
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                    end
                end
            end
            StRun: begin
                carry_d = sl_cout_i;
                idx_d   = idx_q + 1'b1;
                if (!last) begin
                    work_d[idx_q] = sl_result_i;
                end else begin
                    idx_d    = '0;
                    state_d  = StDone;
                    result_d = full_c;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    if (ctrl_q == OpAdd || ctrl_q == OpSub) begin
                        cout_d = sl_cout_i;
                        ovf_d  = ovf_c;
                    end else if (ctrl_q == OpSlt) begin
                        result_d    = '0;
                        result_d[0] = sl_result_i ^ ovf_c;
                    end
                    zero_d = (result_d == '0);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef ALU_SERIAL_ABORT_EN
        // Abort discards the op; visible outputs keep their pre-start values
        if (run && abort_i) begin
            state_d  = StIdle;
            result_d = result_q;
            zero_d   = zero_q;
            cout_d   = cout_q;
            ovf_d    = ovf_q;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            work_q   <= work_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        ainv = 1'b0;
        binv = 1'b0;
        op   = 2'b00;
        case (ctrl_q)
            OpOr:   op = 2'b01;
            OpAdd:  op = 2'b10;
            OpSub:  begin binv = 1'b1; op = 2'b10; end
            OpSlt:  begin binv = 1'b1; op = 2'b10; end
            OpNor:  begin ainv = 1'b1; binv = 1'b1; op = 2'b00; end
            OpNand: begin ainv = 1'b1; binv = 1'b1; op = 2'b01; end
            default: op = 2'b00;
        endcase
    end

    assign sl_src1_o  = run & a_q[idx_q];
    assign sl_src2_o  = run & b_q[idx_q];
    assign sl_cin_o   = run & carry_q;
    assign sl_ainv_o  = run & ainv;
    assign sl_binv_o  = run & binv;
    assign sl_op_o    = run ? op : 2'b00;
    assign sl_less_o  = 1'b0;

    assign busy_o     = run;
    assign done_o     = (state_q == StDone);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer for the 1-bit ALU slice: drives one slice instance LSB-first, one bit per clock, for WIDTH cycles.
- Chains the slice's carry-out back into its carry-in between bits.
- Assembles the WIDTH-bit result and derives zero, carry, overflow and set-less-than.
- Sits between the decoder's ALU control and the register-file write path as a low-area multi-cycle ALU.

Parameters:
WIDTH, 32, operand/result width; WIDTH >= 2.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  request; accepted only in IDLE
ctrl_i  input  4  op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND
src1_i  input  WIDTH  operand A, latched at accept
src2_i  input  WIDTH  operand B, latched at accept
busy_o  output  1  high in RUN
done_o  output  1  one-cycle completion pulse
result_o  output  WIDTH  final result, held until next accept
zero_o  output  1  result_o == 0
cout_o  output  1  final carry (ADD/SUB), else 0
overflow_o  output  1  signed overflow (ADD/SUB), else 0
sl_src1_o  output  1  slice src1
sl_src2_o  output  1  slice src2
sl_cin_o  output  1  slice carry in
sl_ainv_o  output  1  slice A_invert
sl_binv_o  output  1  slice B_invert
sl_op_o  output  2  slice operation (00 and, 01 or, 10 add)
sl_less_o  output  1  slice less, tied 0
sl_result_i  input  1  slice result
sl_cout_i  input  1  slice carry out

Behaviour:
- Reset (asynchronous, active-high): state IDLE.
  - busy_o, done_o, cout_o, overflow_o = 0; result_o = 0; zero_o = 1.
  - Bit index, carry and shift registers cleared.
- States are IDLE, RUN and DONE.
- IDLE + start_i at edge E0:
  - Latch src1_i, src2_i and ctrl_i.
  - Set bit index to 0.
  - Initial carry = 1 for SUB/SLT, 0 otherwise.
  - Go to RUN.
- Unsupported ctrl_i at accept: skip RUN; go directly to DONE with result_o = 0, cout_o = 0, overflow_o = 0.
- Slice mapping (ainv, binv, op):
  - AND: 0,0,00
  - OR: 0,0,01
  - ADD: 0,0,10
  - SUB: 0,1,10
  - SLT: 0,1,10
  - NOR: 1,1,00
  - NAND: 1,1,01
- In RUN, slice outputs are driven combinationally from registered state:
  - sl_src1_o = A[idx], sl_src2_o = B[idx], sl_cin_o = carry register.
  - Slice drive is 0 outside RUN.
- Each RUN edge E1..EWIDTH:
  - Capture sl_result_i into result bit idx.
  - carry <= sl_cout_i; idx <= idx+1.
  - At idx = WIDTH-1, also record the carry-in of the MSB.
- Final RUN edge (EWIDTH), with cmsb = carry-in of MSB and ovf = cmsb ^ sl_cout_i:
  - Update result_o; zero_o is computed from the new result.
  - ADD/SUB: cout_o = sl_cout_i, overflow_o = ovf.
  - SLT: result_o = {WIDTH-1 zeros, sl_result_i ^ ovf}; cout_o = overflow_o = 0.
  - Logic ops: cout_o = overflow_o = 0.
  - Go to DONE.
- DONE: done_o = 1 for exactly this cycle, then return to IDLE.
  - Latency: done_o is high in the cycle after edge EWIDTH, i.e. WIDTH+1 cycles after accept.
- busy_o is 1 in RUN only.
- start_i in RUN or DONE is ignored (not queued). A new start is accepted only from IDLE, so back-to-back throughput is one op per WIDTH+2 cycles.
- Operand or ctrl changes after accept have no effect.
- Reset mid-RUN: immediate return to reset values; no done_o pulse.

Optional Feature:
ALU_SERIAL_ABORT_EN:
- Defined: adds input abort_i (1 bit).
  - abort_i high in RUN returns to IDLE at the next edge.
  - result_o, zero_o, cout_o and overflow_o keep their pre-start values; no done_o.
  - abort_i in IDLE/DONE has no effect.
- Undefined: no abort_i port; every accepted op completes.

Test Plan:
- ADD 7+5 (WIDTH=32) -> done_o exactly 33 cycles after accept; result_o=12, cout_o=0, overflow_o=0, zero_o=0.
- SUB 5-7 -> result_o=0xFFFFFFFE, cout_o=0, overflow_o=0; SUB 9-9 -> result_o=0, zero_o=1, cout_o=1.
- ADD 0x7FFFFFFF+1 -> result_o=0x80000000, overflow_o=1; SLT 0xFFFFFFFF vs 1 -> result_o=1; SLT 0x7FFFFFFF vs 0x80000000 -> result_o=0.
- NOR 0,0 -> 0xFFFFFFFF; NAND 0xF0F0F0F0,0xFF00FF00 -> 0x0FFF0FFF; ctrl_i=1111 -> done_o one cycle after accept, result_o=0.
- start_i held high during RUN with new operands -> first result unchanged, single done_o pulse, next accept only from IDLE.
- rst_i asserted at RUN bit 10 -> outputs at reset values immediately, no done_o; with ALU_SERIAL_ABORT_EN, abort_i at bit 10 -> IDLE next edge, result_o unchanged.
